pic_rw_control: RTL and testbench

Read/write control and initialization sequencer of the 8259-compatible PIC. Sits directly downstream of the data bus buffer: it samples CPU strobes and the 8-bit internal data bus, runs the ICW1–ICW4 initialization sequence, holds the resulting configuration and the interrupt mask, decodes OCW2/OCW3 commands, and selects what the buffer drives back on a CPU read.

---
 rtl/pic_rw_control.sv | 277 +++++++++++++++++++++++++++
 tb/tb_pic_rw_control.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pic_rw_control.sv
// -----------------------------------------------------------------------------
// pic_rw_control
//
// Read/write control and initialization sequencer of an 8259-compatible PIC.
// Samples the CPU strobes and the internal data bus every cycle, commits a
// write on the cycle after the write strobe ends, runs the ICW1..ICW4
// initialization sequence, holds the resulting configuration and the
// interrupt mask, decodes OCW2/OCW3, and selects the CPU read-back byte.
//
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   cs_n, rd_n, wr_n    CPU chip select / read / write strobes (active low)
//   a0                  CPU address bit 0
//   internal_d[7:0]     write data from the data bus buffer
//   irr[7:0], isr[7:0]  request / in-service registers for read-back
//   read_data[7:0]      byte to drive on a CPU read (0 when not reading)
//   read_oe             a valid CPU read is in progress
//   init_done           ICW sequence complete
//   ltim, sngl          ICW1 D3, D1
//   vector_base[4:0]    ICW2 D7:D3
//   cascade_cfg[7:0]    ICW3 byte
//   aeoi, upm           ICW4 D1, D0
//   imr[7:0]            interrupt mask register (OCW1)
//   ocw2_cmd[7:0]       last OCW2 byte
//   ocw2_valid          one-cycle pulse when ocw2_cmd is updated
//   ris, smm            OCW3 read-ISR select, special mask mode
// -----------------------------------------------------------------------------
module pic_rw_control (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cs_n,
    input  logic       rd_n,
    input  logic       wr_n,
    input  logic       a0,
    input  logic [7:0] internal_d,
    input  logic [7:0] irr,
    input  logic [7:0] isr,
    output logic [7:0] read_data,
    output logic       read_oe,
    output logic       init_done,
    output logic       ltim,
    output logic       sngl,
    output logic [4:0] vector_base,
    output logic [7:0] cascade_cfg,
    output logic       aeoi,
    output logic       upm,
    output logic [7:0] imr,
    output logic [7:0] ocw2_cmd,
    output logic       ocw2_valid,
    output logic       ris,
    output logic       smm
);

    typedef enum logic [2:0] {
        ST_UNINIT    = 3'd0,
        ST_WAIT_ICW2 = 3'd1,
        ST_WAIT_ICW3 = 3'd2,
        ST_WAIT_ICW4 = 3'd3,
        ST_READY     = 3'd4
    } state_t;

    // Strobe / bus samples from the previous cycle
    logic       cs_n_r, wr_n_r, rd_n_r, a0_r;
    logic [7:0] data_r;

    // Architectural state
    state_t     state_r, state_s;
    logic       ic4_r, ic4_s;
    logic       init_done_r, init_done_s;
    logic       ltim_r, ltim_s;
    logic       sngl_r, sngl_s;
    logic [4:0] vector_base_r, vector_base_s;
    logic [7:0] cascade_cfg_r, cascade_cfg_s;
    logic       aeoi_r, aeoi_s;
    logic       upm_r, upm_s;
    logic [7:0] imr_r, imr_s;
    logic [7:0] ocw2_cmd_r, ocw2_cmd_s;
    logic       ocw2_valid_r, ocw2_valid_s;
    logic       ris_r, ris_s;
    logic       smm_r, smm_s;

    logic       commit_s;
    logic       read_oe_s;
    logic [7:0] read_data_s;

    // A write that overlapped a read strobe never commits (rd_n_r must be 1).
    assign commit_s = wr_n & ~wr_n_r & ~cs_n_r & rd_n_r;

    // Sample the CPU strobes and data bus every cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_n_r <= 1'b1;
            wr_n_r <= 1'b1;
            rd_n_r <= 1'b1;
            a0_r   <= 1'b0;
            data_r <= 8'h00;
        end else begin
            cs_n_r <= cs_n;
            wr_n_r <= wr_n;
            rd_n_r <= rd_n;
            a0_r   <= a0;
            data_r <= internal_d;
        end
    end

    // Sequencer state and configuration registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_UNINIT;
            ic4_r         <= 1'b0;
            init_done_r   <= 1'b0;
            ltim_r        <= 1'b0;
            sngl_r        <= 1'b0;
            vector_base_r <= 5'd0;
            cascade_cfg_r <= 8'h00;
            aeoi_r        <= 1'b0;
            upm_r         <= 1'b0;
            imr_r         <= 8'h00;
            ocw2_cmd_r    <= 8'h00;
            ocw2_valid_r  <= 1'b0;
            ris_r         <= 1'b0;
            smm_r         <= 1'b0;
        end else begin
            state_r       <= state_s;
            ic4_r         <= ic4_s;
            init_done_r   <= init_done_s;
            ltim_r        <= ltim_s;
            sngl_r        <= sngl_s;
            vector_base_r <= vector_base_s;
            cascade_cfg_r <= cascade_cfg_s;
            aeoi_r        <= aeoi_s;
            upm_r         <= upm_s;
            imr_r         <= imr_s;
            ocw2_cmd_r    <= ocw2_cmd_s;
            ocw2_valid_r  <= ocw2_valid_s;
            ris_r         <= ris_s;
            smm_r         <= smm_s;
        end
    end

    // Next-state and register update decode for a committed write
    always_comb begin
        state_s       = state_r;
        ic4_s         = ic4_r;
        init_done_s   = init_done_r;
        ltim_s        = ltim_r;
        sngl_s        = sngl_r;
        vector_base_s = vector_base_r;
        cascade_cfg_s = cascade_cfg_r;
        aeoi_s        = aeoi_r;
        upm_s         = upm_r;
        imr_s         = imr_r;
        ocw2_cmd_s    = ocw2_cmd_r;
        ocw2_valid_s  = 1'b0;
        ris_s         = ris_r;
        smm_s         = smm_r;

        if (commit_s) begin
            if (!a0_r && data_r[4]) begin
                // ICW1 restarts initialization from any state
                ltim_s      = data_r[3];
                sngl_s      = data_r[1];
                ic4_s       = data_r[0];
                imr_s       = 8'h00;
                ris_s       = 1'b0;
                smm_s       = 1'b0;
                aeoi_s      = 1'b0;
                upm_s       = 1'b0;
                init_done_s = 1'b0;
                state_s     = ST_WAIT_ICW2;
            end else begin
                case (state_r)
                    ST_WAIT_ICW2: begin
                        if (a0_r) begin
                            vector_base_s = data_r[7:3];
                            if (!sngl_r) begin
                                state_s = ST_WAIT_ICW3;
                            end else if (ic4_r) begin
                                state_s = ST_WAIT_ICW4;
                            end else begin
                                state_s     = ST_READY;
                                init_done_s = 1'b1;
                                aeoi_s      = 1'b0;
                                upm_s       = 1'b0;
                            end
                        end else begin
                            state_s = ST_WAIT_ICW2;
                        end
                    end
                    ST_WAIT_ICW3: begin
                        if (a0_r) begin
                            cascade_cfg_s = data_r;
                            if (ic4_r) begin
                                state_s = ST_WAIT_ICW4;
                            end else begin
                                state_s     = ST_READY;
                                init_done_s = 1'b1;
                                aeoi_s      = 1'b0;
                                upm_s       = 1'b0;
                            end
                        end else begin
                            state_s = ST_WAIT_ICW3;
                        end
                    end
                    ST_WAIT_ICW4: begin
                        if (a0_r) begin
                            aeoi_s      = data_r[1];
                            upm_s       = data_r[0];
                            state_s     = ST_READY;
                            init_done_s = 1'b1;
                        end else begin
                            state_s = ST_WAIT_ICW4;
                        end
                    end
                    ST_READY: begin
                        if (a0_r) begin
                            imr_s = data_r;
                        end else if (!data_r[3]) begin
                            ocw2_cmd_s   = data_r;
                            ocw2_valid_s = 1'b1;
                        end else begin
                            // OCW3: each field only updates when its enable bit is set
                            if (data_r[1]) begin
                                ris_s = data_r[0];
                            end else begin
                                ris_s = ris_r;
                            end
                            if (data_r[6]) begin
                                smm_s = data_r[5];
                            end else begin
                                smm_s = smm_r;
                            end
                        end
                    end
                    default: begin
                        state_s = state_r;
                    end
                endcase
            end
        end else begin
            state_s = state_r;
        end
    end

    // Combinational read-back select
    always_comb begin
        read_oe_s   = ~cs_n & ~rd_n & wr_n;
        read_data_s = 8'h00;
        if (read_oe_s) begin
            if (a0) begin
                read_data_s = imr_r;
            end else if (ris_r) begin
                read_data_s = isr;
            end else begin
                read_data_s = irr;
            end
        end else begin
            read_data_s = 8'h00;
        end
    end

    assign read_oe     = read_oe_s;
    assign read_data   = read_data_s;
    assign init_done   = init_done_r;
    assign ltim        = ltim_r;
    assign sngl        = sngl_r;
    assign vector_base = vector_base_r;
    assign cascade_cfg = cascade_cfg_r;
    assign aeoi        = aeoi_r;
    assign upm         = upm_r;
    assign imr         = imr_r;
    assign ocw2_cmd    = ocw2_cmd_r;
    assign ocw2_valid  = ocw2_valid_r;
    assign ris         = ris_r;
    assign smm         = smm_r;

endmodule

// File: tb/tb_pic_rw_control.sv
// -----------------------------------------------------------------------------
// tb_pic_rw_control
//
// Scoreboard bench for pic_rw_control. Stimulus tasks push expected values
// into queues; one monitor process pops and compares when the DUT presents
// an ocw2_valid pulse, a read_oe cycle, or when a register check is requested.
// -----------------------------------------------------------------------------
module tb_pic_rw_control;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cs_n, rd_n, wr_n, a0;
    logic [7:0] din, irr, isr;
    logic [7:0] read_data, imr, ocw2_cmd, cascade_cfg;
    logic [4:0] vector_base;
    logic       read_oe, init_done, ltim, sngl, aeoi, upm, ocw2_valid, ris, smm;

    typedef struct {
        int         id;
        logic [7:0] val;
    } exp_t;

    exp_t       st_q[$];
    logic [7:0] rd_q[$];
    logic [7:0] ocw2_q[$];

    int   errors = 0;
    int   checks = 0;
    logic chk_req = 1'b0;
    logic end_req = 1'b0;
    logic mon_done = 1'b0;

    pic_rw_control dut (
        .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n),
        .a0(a0), .internal_d(din), .irr(irr), .isr(isr),
        .read_data(read_data), .read_oe(read_oe), .init_done(init_done),
        .ltim(ltim), .sngl(sngl), .vector_base(vector_base),
        .cascade_cfg(cascade_cfg), .aeoi(aeoi), .upm(upm), .imr(imr),
        .ocw2_cmd(ocw2_cmd), .ocw2_valid(ocw2_valid), .ris(ris), .smm(smm)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] get_out(input int id);
        case (id)
            0:  get_out = {7'd0, init_done};
            1:  get_out = {7'd0, ltim};
            2:  get_out = {7'd0, sngl};
            3:  get_out = {3'd0, vector_base};
            4:  get_out = cascade_cfg;
            5:  get_out = {7'd0, aeoi};
            6:  get_out = {7'd0, upm};
            7:  get_out = imr;
            8:  get_out = ocw2_cmd;
            9:  get_out = {7'd0, ris};
            10: get_out = {7'd0, smm};
            11: get_out = {7'd0, read_oe};
            12: get_out = read_data;
            13: get_out = {7'd0, ocw2_valid};
            default: get_out = 8'hxx;
        endcase
    endfunction

    function automatic string get_name(input int id);
        case (id)
            0:  get_name = "init_done";
            1:  get_name = "ltim";
            2:  get_name = "sngl";
            3:  get_name = "vector_base";
            4:  get_name = "cascade_cfg";
            5:  get_name = "aeoi";
            6:  get_name = "upm";
            7:  get_name = "imr";
            8:  get_name = "ocw2_cmd";
            9:  get_name = "ris";
            10: get_name = "smm";
            11: get_name = "read_oe";
            12: get_name = "read_data";
            13: get_name = "ocw2_valid";
            default: get_name = "unknown";
        endcase
    endfunction

    // Monitor: all comparisons happen here, on the falling edge
    initial begin
        exp_t       e;
        logic [7:0] v;
        forever begin
            @(negedge clk);
            if (ocw2_valid) begin
                checks++;
                if (ocw2_q.size() == 0) begin
                    errors++;
                    $display("FAIL ocw2_pulse: got unexpected ocw2_valid cmd=%02h, required no pulse", ocw2_cmd);
                end else begin
                    v = ocw2_q.pop_front();
                    if (ocw2_cmd !== v) begin
                        errors++;
                        $display("FAIL ocw2_cmd: got %02h required %02h", ocw2_cmd, v);
                    end
                end
            end
            if (read_oe) begin
                checks++;
                if (rd_q.size() == 0) begin
                    errors++;
                    $display("FAIL read_oe: got unexpected read_oe=1 data=%02h, required 0", read_data);
                end else begin
                    v = rd_q.pop_front();
                    if (read_data !== v) begin
                        errors++;
                        $display("FAIL read_data: got %02h required %02h", read_data, v);
                    end
                end
            end
            if (chk_req) begin
                while (st_q.size() > 0) begin
                    e = st_q.pop_front();
                    checks++;
                    if (get_out(e.id) !== e.val) begin
                        errors++;
                        $display("FAIL %s: got %02h required %02h", get_name(e.id), get_out(e.id), e.val);
                    end
                end
            end
            if (end_req && !mon_done) begin
                checks++;
                if (ocw2_q.size() != 0) begin
                    errors++;
                    $display("FAIL ocw2_missing: got %0d pending pulses, required 0", ocw2_q.size());
                end
                checks++;
                if (rd_q.size() != 0) begin
                    errors++;
                    $display("FAIL read_missing: got %0d pending reads, required 0", rd_q.size());
                end
                mon_done = 1'b1;
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic expect_val(input int id, input logic [7:0] v);
        exp_t e;
        e.id = id;
        e.val = v;
        st_q.push_back(e);
    endtask

    task automatic check_now();
        chk_req = 1'b1;
        @(posedge clk); #1;
        chk_req = 1'b0;
    endtask

    // Called at posedge+1; returns at posedge+1 just after the commit edge
    task automatic do_write(input logic a, input logic [7:0] d);
        cs_n = 1'b0; wr_n = 1'b0; a0 = a; din = d;
        @(posedge clk); #1;
        wr_n = 1'b1; cs_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // One-cycle read: exactly one falling edge sees read_oe
    task automatic do_read(input logic a, input logic [7:0] v);
        rd_q.push_back(v);
        cs_n = 1'b0; rd_n = 1'b0; a0 = a;
        @(posedge clk); #1;
        rd_n = 1'b1; cs_n = 1'b1;
    endtask

    task automatic expect_all_zero();
        for (int i = 0; i <= 13; i++) expect_val(i, 8'h00);
    endtask

    initial begin
        rst_n = 1'b0; cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; a0 = 1'b0;
        din = 8'h00; irr = 8'h80; isr = 8'h04;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset state, UNINIT ignores OCW1
        expect_all_zero();
        check_now();
        do_write(1'b1, 8'hFF);
        expect_val(7, 8'h00); expect_val(0, 8'h00);
        check_now();

        // Single, IC4: ICW1 0x13, ICW2 0x40, ICW4 0x03
        do_write(1'b0, 8'h13);
        do_write(1'b1, 8'h40);
        expect_val(0, 8'h00);
        check_now();
        do_write(1'b1, 8'h03);
        expect_val(0, 8'h01); expect_val(3, 8'h08); expect_val(5, 8'h01);
        expect_val(6, 8'h01); expect_val(4, 8'h00); expect_val(2, 8'h01);
        expect_val(1, 8'h00);
        check_now();

        // Cascade, no IC4: ICW1 0x10, ICW2 0x20, ICW3 0x04
        do_write(1'b0, 8'h10);
        expect_val(0, 8'h00); expect_val(5, 8'h00); expect_val(6, 8'h00);
        check_now();
        do_write(1'b1, 8'h20);
        do_write(1'b1, 8'h04);
        expect_val(0, 8'h01); expect_val(4, 8'h04); expect_val(5, 8'h00);
        expect_val(3, 8'h04); expect_val(2, 8'h00);
        check_now();
        do_write(1'b1, 8'hA5);
        expect_val(7, 8'hA5);
        check_now();
        do_read(1'b1, 8'hA5);

        // OCW2 pulse, OCW3 read select and special mask mode
        ocw2_q.push_back(8'h20);
        do_write(1'b0, 8'h20);
        expect_val(8, 8'h20);
        check_now();
        expect_val(13, 8'h00);
        check_now();
        do_write(1'b0, 8'h0B);
        expect_val(9, 8'h01);
        check_now();
        do_read(1'b0, 8'h04);
        do_write(1'b0, 8'h0A);
        do_read(1'b0, 8'h80);
        do_write(1'b0, 8'h68);
        expect_val(10, 8'h01); expect_val(9, 8'h00); expect_val(7, 8'hA5);
        check_now();

        // ICW1 mid-READY; later a0=0 non-ICW1 write is ignored
        do_write(1'b0, 8'h13);
        expect_val(7, 8'h00); expect_val(0, 8'h00); expect_val(10, 8'h00);
        check_now();
        do_write(1'b0, 8'h20);
        expect_val(8, 8'h20);
        check_now();

        // Reach WAIT_ICW3, then reset with a write in flight
        do_write(1'b0, 8'h10);
        do_write(1'b1, 8'h20);
        cs_n = 1'b0; wr_n = 1'b0; a0 = 1'b1; din = 8'h55;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        wr_n = 1'b1; cs_n = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        expect_all_zero();
        check_now();
        do_write(1'b1, 8'hFF);
        expect_val(7, 8'h00);
        check_now();

        // LTIM + single, no IC4, then overlapping rd_n/wr_n must not commit
        do_write(1'b0, 8'h1A);
        do_write(1'b1, 8'h08);
        expect_val(0, 8'h01); expect_val(1, 8'h01); expect_val(2, 8'h01);
        expect_val(3, 8'h01); expect_val(5, 8'h00);
        check_now();
        cs_n = 1'b0; rd_n = 1'b0; wr_n = 1'b0; a0 = 1'b1; din = 8'h3C;
        repeat (2) @(posedge clk);
        #1;
        wr_n = 1'b1; rd_n = 1'b1; cs_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        expect_val(7, 8'h00);
        check_now();
        do_write(1'b1, 8'h3C);
        expect_val(7, 8'h3C);
        check_now();
        do_read(1'b1, 8'h3C);

        end_req = 1'b1;
        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
